wd_supervisor: RTL and testbench

- Service/escalation controller directly upstream of the frame window counter.
- Sources its service and reset inputs (WDSRVC, WDRST), consumes its overflow flag FWOVR, and enforces a windowed watchdog.
- Service requests arriving too early (before OPEN_LEN cycles) or too late (FWOVR) are faults; MAX_FAULTS accumulated faults trip a timed system reset.

---
 rtl/wd_pkg.sv | 25 ++
 rtl/wd_window_cnt.sv | 28 ++
 rtl/wd_supervisor.sv | 184 ++++++++++++++++++
 tb/tb_wd_supervisor.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/wd_pkg.sv
// Shared types and constants for the windowed watchdog supervisor.
package wd_pkg;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    RECOVER  = 2'd2,
    TRIP     = 2'd3
  } wd_state_e;

  // Cycles a stuck overflow may persist in RECOVER before escalating
  localparam int RECOVER_TMO = 4;

  localparam int WIN_W = 16;
  localparam logic [WIN_W-1:0] WIN_MAX = '1;

  // Width needed to hold values 0..value-1, never less than one bit
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/wd_window_cnt.sv
// Saturating open-window counter: counts cycles since frame start and
// reports whether the service window has opened.
module wd_window_cnt
  import wd_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             en,
  input  logic [WIN_W-1:0] open_len,
  output logic             open_ok
);

  logic [WIN_W-1:0] win_q;

  // Clear wins over counting; the count sticks at all-ones
  always_ff @(posedge CLK) begin
    if (RST)
      win_q <= '0;
    else if (clr)
      win_q <= '0;
    else if (en && (win_q != WIN_MAX))
      win_q <= win_q + 1'b1;
  end

  assign open_ok = (win_q >= open_len);

endmodule

// File: rtl/wd_supervisor.sv
// Windowed watchdog supervisor: services the frame window, classifies early
// and late services as faults, and escalates to a timed system reset.
// Optional build macro WD_FAULT_DECAY_EN: consecutive good services slowly
// forgive accumulated faults.
module wd_supervisor
  import wd_pkg::*;
#(
  parameter int MAX_FAULTS = 3,
  parameter int FCW        = 4,
  parameter int TRIP_LEN   = 16,
  parameter int DECAY_SVCS = 8
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           ARM,
  input  logic           SVC_REQ,
  input  logic           FWOVR,
  input  logic [15:0]    OPEN_LEN,
  output logic           WDSRVC,
  output logic           WDRST,
  output logic           SYS_RST,
  output logic [FCW-1:0] FAULT_CNT,
  output logic           EARLY_ERR,
  output logic           LATE_ERR,
  output logic [1:0]     STATE
);

  localparam int TW    = clog2(TRIP_LEN + 1);
  localparam int REC_W = clog2(RECOVER_TMO + 1);
  localparam logic [TW-1:0]    TRIP_LAST = TW'(TRIP_LEN - 1);
  localparam logic [REC_W-1:0] REC_LAST  = REC_W'(RECOVER_TMO - 1);
  localparam logic [FCW-1:0]   MAXF      = FCW'(MAX_FAULTS);
  localparam logic [FCW-1:0]   FAULT_SAT = '1;

  wd_state_e        state_q, state_d;
  logic [TW-1:0]    trip_q, trip_d;
  logic [REC_W-1:0] rec_q, rec_d;
  logic [FCW-1:0]   fault_inc, fault_nxt, fault_dec;
  logic             wdsrvc_d, wdrst_d, sys_rst_d, early_d, late_d;
  logic             win_clr, win_en, open_ok;

  wd_window_cnt u_win (
    .CLK      (CLK),
    .RST      (RST),
    .clr      (win_clr),
    .en       (win_en),
    .open_len (OPEN_LEN),
    .open_ok  (open_ok)
  );

  assign fault_inc = (FAULT_CNT == FAULT_SAT) ? FAULT_CNT : FAULT_CNT + 1'b1;

  // Next-state and next-output decode; every output is registered below
  always_comb begin
    state_d   = state_q;
    trip_d    = trip_q;
    rec_d     = rec_q;
    fault_nxt = FAULT_CNT;
    wdsrvc_d  = 1'b0;
    wdrst_d   = 1'b0;
    sys_rst_d = 1'b0;
    early_d   = 1'b0;
    late_d    = 1'b0;
    win_clr   = 1'b0;
    win_en    = 1'b0;
    case (state_q)
      DISARMED: begin
        if (ARM) begin
          state_d = ARMED;
          win_clr = 1'b1;
        end else begin
          wdrst_d = 1'b1;
        end
      end
      ARMED: begin
        win_en = 1'b1;
        if (!ARM) begin
          state_d = DISARMED;
          wdrst_d = 1'b1;
        end else if (FWOVR) begin
          late_d    = 1'b1;
          fault_nxt = fault_inc;
          wdrst_d   = 1'b1;
          rec_d     = '0;
          state_d   = RECOVER;
        end else if (SVC_REQ) begin
          early_d   = !open_ok;
          fault_nxt = open_ok ? FAULT_CNT : fault_inc;
          wdsrvc_d  = 1'b1;
          win_clr   = 1'b1;
        end
        if ((late_d || early_d) && (fault_inc >= MAXF)) begin
          state_d   = TRIP;
          trip_d    = '0;
          sys_rst_d = 1'b1;
          wdrst_d   = 1'b1;
          wdsrvc_d  = 1'b0;
        end
      end
      RECOVER: begin
        if (!FWOVR) begin
          state_d = ARMED;
          win_clr = 1'b1;
        end else if (rec_q == REC_LAST) begin
          state_d   = TRIP;
          trip_d    = '0;
          sys_rst_d = 1'b1;
          wdrst_d   = 1'b1;
        end else begin
          rec_d   = rec_q + 1'b1;
          wdrst_d = 1'b1;
        end
      end
      TRIP: begin
        wdrst_d = 1'b1;
        if (trip_q == TRIP_LAST) begin
          state_d   = DISARMED;
          fault_nxt = '0;
        end else begin
          trip_d    = trip_q + 1'b1;
          sys_rst_d = 1'b1;
        end
      end
      default: begin
        state_d = DISARMED;
        wdrst_d = 1'b1;
      end
    endcase
  end

`ifdef WD_FAULT_DECAY_EN
  localparam int DW = clog2(DECAY_SVCS + 1);

  logic [DW-1:0] good_q;
  logic          good_svc, clr_good, decay_hit;

  assign good_svc  = (state_q == ARMED) && ARM && !FWOVR && SVC_REQ && open_ok;
  assign clr_good  = (state_q != ARMED) || !ARM || FWOVR || (SVC_REQ && !open_ok);
  assign decay_hit = good_svc && (good_q == DW'(DECAY_SVCS - 1));
  assign fault_dec = (decay_hit && (fault_nxt != '0)) ? fault_nxt - 1'b1 : fault_nxt;

  // Run length of consecutive good services since the last fault or disarm
  always_ff @(posedge CLK) begin
    if (RST)
      good_q <= '0;
    else if (clr_good || decay_hit)
      good_q <= '0;
    else if (good_svc)
      good_q <= good_q + 1'b1;
  end
`else
  logic [31:0] unused_decay_svcs;
  assign unused_decay_svcs = DECAY_SVCS;
  assign fault_dec = fault_nxt;
`endif

  // State, timers and registered outputs; reset overrides everything
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= DISARMED;
      trip_q    <= '0;
      rec_q     <= '0;
      FAULT_CNT <= '0;
      WDSRVC    <= 1'b0;
      WDRST     <= 1'b1;
      SYS_RST   <= 1'b0;
      EARLY_ERR <= 1'b0;
      LATE_ERR  <= 1'b0;
    end else begin
      state_q   <= state_d;
      trip_q    <= trip_d;
      rec_q     <= rec_d;
      FAULT_CNT <= fault_dec;
      WDSRVC    <= wdsrvc_d;
      WDRST     <= wdrst_d;
      SYS_RST   <= sys_rst_d;
      EARLY_ERR <= early_d;
      LATE_ERR  <= late_d;
    end
  end

  assign STATE = state_q;

endmodule

// File: tb/tb_wd_supervisor.sv
// Directed testbench for wd_supervisor with default parameters
// (MAX_FAULTS=3, FCW=4, TRIP_LEN=16, DECAY_SVCS=8).
module tb_wd_supervisor;

  logic        CLK;
  logic        RST;
  logic        ARM;
  logic        SVC_REQ;
  logic        FWOVR;
  logic [15:0] OPEN_LEN;
  logic        WDSRVC;
  logic        WDRST;
  logic        SYS_RST;
  logic [3:0]  FAULT_CNT;
  logic        EARLY_ERR;
  logic        LATE_ERR;
  logic [1:0]  STATE;

  int compared;
  int mismatched;

  wd_supervisor dut (
    .CLK       (CLK),
    .RST       (RST),
    .ARM       (ARM),
    .SVC_REQ   (SVC_REQ),
    .FWOVR     (FWOVR),
    .OPEN_LEN  (OPEN_LEN),
    .WDSRVC    (WDSRVC),
    .WDRST     (WDRST),
    .SYS_RST   (SYS_RST),
    .FAULT_CNT (FAULT_CNT),
    .EARLY_ERR (EARLY_ERR),
    .LATE_ERR  (LATE_ERR),
    .STATE     (STATE)
  );

  // Free-running clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "[TB] timeout");
  end

  // Advance n rising edges and settle just after the last one
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; ARM = 1'b0; SVC_REQ = 1'b0; FWOVR = 1'b0; OPEN_LEN = 16'd10;
    tick(2);
    compared++; if (STATE !== 2'd0) begin mismatched++; $display("[TB] FAIL reset_state: got %0d expected 0", STATE); end
    compared++; if (WDRST !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_wdrst: got %0b expected 1", WDRST); end
    compared++; if ({WDSRVC, SYS_RST, EARLY_ERR, LATE_ERR} !== 4'b0) begin mismatched++; $display("[TB] FAIL reset_pulses: got %b expected 0000", {WDSRVC, SYS_RST, EARLY_ERR, LATE_ERR}); end
    compared++; if (FAULT_CNT !== 4'd0) begin mismatched++; $display("[TB] FAIL reset_faults: got %0d expected 0", FAULT_CNT); end
    RST = 1'b0;
    tick(1);
    compared++; if (WDRST !== 1'b1) begin mismatched++; $display("[TB] FAIL disarmed_wdrst: got %0b expected 1", WDRST); end
    ARM = 1'b1;
    tick(1);
    compared++; if (STATE !== 2'd1) begin mismatched++; $display("[TB] FAIL arm_state: got %0d expected 1", STATE); end
    compared++; if (WDRST !== 1'b0) begin mismatched++; $display("[TB] FAIL arm_wdrst: got %0b expected 0", WDRST); end
  endtask

  // win_q is 0 right after arming; service when it reads 12
  task automatic test_good_service();
    tick(12);
    SVC_REQ = 1'b1;
    tick(1);
    SVC_REQ = 1'b0;
    compared++; if (WDSRVC !== 1'b1) begin mismatched++; $display("[TB] FAIL good_wdsrvc: got %0b expected 1", WDSRVC); end
    compared++; if (EARLY_ERR !== 1'b0) begin mismatched++; $display("[TB] FAIL good_early: got %0b expected 0", EARLY_ERR); end
    compared++; if (FAULT_CNT !== 4'd0) begin mismatched++; $display("[TB] FAIL good_faults: got %0d expected 0", FAULT_CNT); end
    tick(1);
    compared++; if (WDSRVC !== 1'b0) begin mismatched++; $display("[TB] FAIL good_wdsrvc_width: got %0b expected 0", WDSRVC); end
  endtask

  // win_q is 1 on entry; service at win_q=3
  task automatic test_early_service();
    tick(2);
    SVC_REQ = 1'b1;
    tick(1);
    SVC_REQ = 1'b0;
    compared++; if (EARLY_ERR !== 1'b1) begin mismatched++; $display("[TB] FAIL early_err: got %0b expected 1", EARLY_ERR); end
    compared++; if (FAULT_CNT !== 4'd1) begin mismatched++; $display("[TB] FAIL early_faults: got %0d expected 1", FAULT_CNT); end
    compared++; if (WDSRVC !== 1'b1) begin mismatched++; $display("[TB] FAIL early_wdsrvc: got %0b expected 1", WDSRVC); end
    compared++; if (STATE !== 2'd1) begin mismatched++; $display("[TB] FAIL early_state: got %0d expected 1", STATE); end
    tick(1);
    compared++; if (EARLY_ERR !== 1'b0) begin mismatched++; $display("[TB] FAIL early_err_width: got %0b expected 0", EARLY_ERR); end
  endtask

  // win_q is 1 on entry; service exactly at win_q=OPEN_LEN=10 is good
  task automatic test_window_boundary();
    tick(9);
    SVC_REQ = 1'b1;
    tick(1);
    SVC_REQ = 1'b0;
    compared++; if (WDSRVC !== 1'b1) begin mismatched++; $display("[TB] FAIL boundary_wdsrvc: got %0b expected 1", WDSRVC); end
    compared++; if (EARLY_ERR !== 1'b0) begin mismatched++; $display("[TB] FAIL boundary_early: got %0b expected 0", EARLY_ERR); end
    compared++; if (FAULT_CNT !== 4'd1) begin mismatched++; $display("[TB] FAIL boundary_faults: got %0d expected 1", FAULT_CNT); end
    tick(1);
  endtask

  // Overflow with a simultaneous service: late fault wins, service dropped
  task automatic test_late_fault();
    FWOVR = 1'b1; SVC_REQ = 1'b1;
    tick(1);
    SVC_REQ = 1'b0;
    compared++; if (LATE_ERR !== 1'b1) begin mismatched++; $display("[TB] FAIL late_err: got %0b expected 1", LATE_ERR); end
    compared++; if (WDSRVC !== 1'b0) begin mismatched++; $display("[TB] FAIL late_no_wdsrvc: got %0b expected 0", WDSRVC); end
    compared++; if (WDRST !== 1'b1) begin mismatched++; $display("[TB] FAIL late_wdrst: got %0b expected 1", WDRST); end
    compared++; if (STATE !== 2'd2) begin mismatched++; $display("[TB] FAIL late_state: got %0d expected 2", STATE); end
    compared++; if (FAULT_CNT !== 4'd2) begin mismatched++; $display("[TB] FAIL late_faults: got %0d expected 2", FAULT_CNT); end
    tick(1);
    compared++; if (WDRST !== 1'b1) begin mismatched++; $display("[TB] FAIL recover_hold_wdrst: got %0b expected 1", WDRST); end
    compared++; if (LATE_ERR !== 1'b0) begin mismatched++; $display("[TB] FAIL late_err_width: got %0b expected 0", LATE_ERR); end
    FWOVR = 1'b0;
    tick(1);
    compared++; if (STATE !== 2'd1) begin mismatched++; $display("[TB] FAIL recover_exit_state: got %0d expected 1", STATE); end
    compared++; if (WDRST !== 1'b0) begin mismatched++; $display("[TB] FAIL recover_exit_wdrst: got %0b expected 0", WDRST); end
  endtask

  // Third fault (early at win_q=9) trips; SYS_RST lasts 16 cycles
  task automatic test_trip();
    int hi;
    tick(9);
    SVC_REQ = 1'b1;
    tick(1);
    compared++; if (EARLY_ERR !== 1'b1) begin mismatched++; $display("[TB] FAIL trip_err: got %0b expected 1", EARLY_ERR); end
    compared++; if (STATE !== 2'd3) begin mismatched++; $display("[TB] FAIL trip_state: got %0d expected 3", STATE); end
    compared++; if (FAULT_CNT !== 4'd3) begin mismatched++; $display("[TB] FAIL trip_faults: got %0d expected 3", FAULT_CNT); end
    compared++; if (WDRST !== 1'b1) begin mismatched++; $display("[TB] FAIL trip_wdrst: got %0b expected 1", WDRST); end
    hi = 0;
    while (SYS_RST === 1'b1 && hi < 40) begin
      hi++;
      tick(1);
      if (WDSRVC !== 1'b0) hi = 100;
    end
    SVC_REQ = 1'b0;
    compared++; if (hi !== 16) begin mismatched++; $display("[TB] FAIL trip_length: got %0d expected 16 cycles", hi); end
    compared++; if (STATE !== 2'd0) begin mismatched++; $display("[TB] FAIL trip_exit_state: got %0d expected 0", STATE); end
    compared++; if (FAULT_CNT !== 4'd0) begin mismatched++; $display("[TB] FAIL trip_exit_faults: got %0d expected 0", FAULT_CNT); end
    compared++; if (WDRST !== 1'b1) begin mismatched++; $display("[TB] FAIL trip_exit_wdrst: got %0b expected 1", WDRST); end
  endtask

  // Stuck overflow escalates after 4 RECOVER cycles; reset aborts the trip
  task automatic test_stuck_overflow();
    tick(1);
    compared++; if (STATE !== 2'd1) begin mismatched++; $display("[TB] FAIL rearm_state: got %0d expected 1", STATE); end
    FWOVR = 1'b1;
    tick(1);
    compared++; if (FAULT_CNT !== 4'd1) begin mismatched++; $display("[TB] FAIL stuck_faults: got %0d expected 1", FAULT_CNT); end
    tick(3);
    compared++; if (STATE !== 2'd2) begin mismatched++; $display("[TB] FAIL stuck_still_recover: got %0d expected 2", STATE); end
    tick(1);
    compared++; if (STATE !== 2'd3) begin mismatched++; $display("[TB] FAIL stuck_trip_state: got %0d expected 3", STATE); end
    compared++; if (SYS_RST !== 1'b1) begin mismatched++; $display("[TB] FAIL stuck_sys_rst: got %0b expected 1", SYS_RST); end
    tick(3);
    RST = 1'b1;
    tick(1);
    compared++; if (STATE !== 2'd0) begin mismatched++; $display("[TB] FAIL abort_state: got %0d expected 0", STATE); end
    compared++; if (SYS_RST !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_sys_rst: got %0b expected 0", SYS_RST); end
    compared++; if (WDRST !== 1'b1) begin mismatched++; $display("[TB] FAIL abort_wdrst: got %0b expected 1", WDRST); end
    compared++; if (FAULT_CNT !== 4'd0) begin mismatched++; $display("[TB] FAIL abort_faults: got %0d expected 0", FAULT_CNT); end
    RST = 1'b0; FWOVR = 1'b0; ARM = 1'b0;
    tick(1);
  endtask

  // One early fault, then OPEN_LEN=0 makes an immediate service good; disarm keeps the count
  task automatic test_open_zero_and_disarm();
    ARM = 1'b1; OPEN_LEN = 16'd10;
    tick(1);
    SVC_REQ = 1'b1;
    tick(1);
    SVC_REQ = 1'b0;
    compared++; if (FAULT_CNT !== 4'd1) begin mismatched++; $display("[TB] FAIL immediate_early_faults: got %0d expected 1", FAULT_CNT); end
    tick(1);
    OPEN_LEN = 16'd0; SVC_REQ = 1'b1;
    tick(1);
    SVC_REQ = 1'b0;
    compared++; if (WDSRVC !== 1'b1) begin mismatched++; $display("[TB] FAIL open_zero_wdsrvc: got %0b expected 1", WDSRVC); end
    compared++; if (EARLY_ERR !== 1'b0) begin mismatched++; $display("[TB] FAIL open_zero_early: got %0b expected 0", EARLY_ERR); end
    ARM = 1'b0;
    tick(1);
    compared++; if (STATE !== 2'd0) begin mismatched++; $display("[TB] FAIL disarm_state: got %0d expected 0", STATE); end
    compared++; if (WDRST !== 1'b1) begin mismatched++; $display("[TB] FAIL disarm_wdrst: got %0b expected 1", WDRST); end
    compared++; if (FAULT_CNT !== 4'd1) begin mismatched++; $display("[TB] FAIL disarm_keeps_faults: got %0d expected 1", FAULT_CNT); end
  endtask

  // FAULT_CNT=2 then 8 good services: decays to 1 only when the feature is built in
  task automatic test_decay();
    logic [3:0] exp_final;
`ifdef WD_FAULT_DECAY_EN
    exp_final = 4'd1;
`else
    exp_final = 4'd2;
`endif
    ARM = 1'b1; OPEN_LEN = 16'd10;
    tick(1);
    SVC_REQ = 1'b1;
    tick(1);
    SVC_REQ = 1'b0; OPEN_LEN = 16'd0;
    compared++; if (FAULT_CNT !== 4'd2) begin mismatched++; $display("[TB] FAIL decay_start: got %0d expected 2", FAULT_CNT); end
    tick(1);
    for (int i = 0; i < 7; i++) begin
      SVC_REQ = 1'b1; tick(1);
      SVC_REQ = 1'b0; tick(1);
    end
    compared++; if (FAULT_CNT !== 4'd2) begin mismatched++; $display("[TB] FAIL decay_after7: got %0d expected 2", FAULT_CNT); end
    SVC_REQ = 1'b1; tick(1);
    SVC_REQ = 1'b0;
    compared++; if (FAULT_CNT !== exp_final) begin mismatched++; $display("[TB] FAIL decay_after8: got %0d expected %0d", FAULT_CNT, exp_final); end
    tick(1);
  endtask

  // Scenario sequence
  initial begin
    compared = 0;
    mismatched = 0;
    test_reset();
    test_good_service();
    test_early_service();
    test_window_boundary();
    test_late_fault();
    test_trip();
    test_stuck_overflow();
    test_open_zero_and_disarm();
    test_decay();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
